// File: rtl/ff_scan_chain_ctrl.sv
// ---------------------------------------------------------------------------
// ff_scan_chain_ctrl
//
// Sequencer for the ff_phy scan path. One operation shifts CHAIN_LEN pattern
// bits into the chain head while the previous chain contents leave the tail.
// It can optionally fire one functional capture clock, after which the chain
// is released. Each shift beat is a ready/valid handshake on both streams:
// a pattern bit enters the head on the same edge that a response bit leaves
// the tail, so no bit is lost or duplicated. Stalls are unbounded.
//
// Parameters
//   CHAIN_LEN      number of GC_FFN cells in the chain (>= 2)
//   CNT_W          width of the shift-beat counter
//
// Ports
//   clk            controller and chain clock (same net as ff_phy_C)
//   global_resetn  asynchronous active-low reset
//   start          begin one operation; level, sampled in IDLE/DONE
//   capture_en     sampled with start: 1 = capture cycle after the shift
//   busy           high in SHIFT and CAPTURE
//   done           one-cycle pulse when an operation completes
//   s_valid/s_data/s_ready   pattern stream into the chain head
//   m_valid/m_data/m_ready   response stream out of the chain tail
//   scan_mode, scan_en, scan_ce, scan_si   drives to ff_phy
//   scan_so        chain tail output from ff_phy
//
// Build option
//   SCAN_CTRL_ABORT_EN : adds input abort and sticky output aborted. An abort
//   in SHIFT or CAPTURE returns to IDLE on the next edge with no beat or
//   capture on that edge and no done pulse.
//
// All outputs are combinational from state and handshake inputs.
// ---------------------------------------------------------------------------
module ff_scan_chain_ctrl #(
    parameter int unsigned CHAIN_LEN = 32,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN)
) (
    input  logic clk,
    input  logic global_resetn,
`ifdef SCAN_CTRL_ABORT_EN
    input  logic abort,
    output logic aborted,
`endif
    input  logic start,
    input  logic capture_en,
    output logic busy,
    output logic done,
    input  logic s_valid,
    input  logic s_data,
    output logic s_ready,
    output logic m_valid,
    output logic m_data,
    input  logic m_ready,
    output logic scan_mode,
    output logic scan_en,
    output logic scan_ce,
    output logic scan_si,
    input  logic scan_so
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cap_q, cap_d;
    logic             abort_req;
    logic             beat;

`ifdef SCAN_CTRL_ABORT_EN
    logic aborted_q, aborted_d;

    assign abort_req = abort;
    assign aborted   = aborted_q;
`else
    assign abort_req = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge global_resetn) begin
        if (!global_resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cap_q     <= 1'b0;
`ifdef SCAN_CTRL_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cap_q     <= cap_d;
`ifdef SCAN_CTRL_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap_d     = cap_q;
`ifdef SCAN_CTRL_ABORT_EN
        aborted_d = aborted_q;
`endif
        beat      = 1'b0;

        busy      = 1'b0;
        done      = 1'b0;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        m_data    = 1'b0;
        scan_mode = 1'b0;
        scan_en   = 1'b0;
        scan_ce   = 1'b0;
        scan_si   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SHIFT;
                    cap_d     = capture_en;
                    cnt_d     = '0;
`ifdef SCAN_CTRL_ABORT_EN
                    aborted_d = 1'b0;
`endif
                end
            end

            ST_SHIFT: begin
                busy      = 1'b1;
                scan_mode = 1'b1;
                scan_en   = 1'b1;
                scan_si   = s_data;
                m_data    = scan_so;
                // An abort suppresses the handshake on both streams so that
                // neither side believes a bit moved on the aborting edge.
                s_ready   = m_ready & ~abort_req;
                m_valid   = s_valid & ~abort_req;
                beat      = s_valid & m_ready & ~abort_req;
                scan_ce   = beat;

                if (abort_req) begin
                    state_d   = ST_IDLE;
`ifdef SCAN_CTRL_ABORT_EN
                    aborted_d = 1'b1;
`endif
                end else if (beat) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = cap_q ? ST_CAPTURE : ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_CAPTURE: begin
                busy = 1'b1;
                // scan_en low with E high loads every FF from its D input.
                scan_ce = ~abort_req;
                if (abort_req) begin
                    state_d   = ST_IDLE;
`ifdef SCAN_CTRL_ABORT_EN
                    aborted_d = 1'b1;
`endif
                end else begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                done = 1'b1;
                // Accepting start here gives back-to-back operations.
                if (start) begin
                    state_d   = ST_SHIFT;
                    cap_d     = capture_en;
                    cnt_d     = '0;
`ifdef SCAN_CTRL_ABORT_EN
                    aborted_d = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ff_scan_chain_ctrl.sv
module tb_ff_scan_chain_ctrl;

    localparam int unsigned LEN = 4;

    logic clk = 1'b0;
    logic global_resetn;
    logic start, capture_en, s_valid, s_data, m_ready;
    logic busy, done, s_ready, m_valid, m_data;
    logic scan_mode, scan_en, scan_ce, scan_si, scan_so;
`ifdef SCAN_CTRL_ABORT_EN
    logic abort, aborted;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ff_scan_chain_ctrl #(.CHAIN_LEN(LEN)) dut (
        .clk           (clk),
        .global_resetn (global_resetn),
`ifdef SCAN_CTRL_ABORT_EN
        .abort         (abort),
        .aborted       (aborted),
`endif
        .start         (start),
        .capture_en    (capture_en),
        .busy          (busy),
        .done          (done),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_ready       (m_ready),
        .scan_mode     (scan_mode),
        .scan_en       (scan_en),
        .scan_ce       (scan_ce),
        .scan_si       (scan_si),
        .scan_so       (scan_so)
    );

    // Behavioural GC_FFN chain: head at bit 0, tail at bit LEN-1, D tied 0.
    logic [LEN-1:0] chain = '0;
    assign scan_so = chain[LEN-1];
    always @(posedge clk) begin
        if (scan_ce) begin
            if (scan_en) chain <= {chain[LEN-2:0], scan_si};
            else         chain <= '0;
        end
    end

    // Scoreboard: expected chain contents, tail bit at the front.
    logic sb[$];

    // Expected control bits: {busy,done,scan_mode,scan_en,scan_ce,s_ready,m_valid,scan_si}
    localparam logic [7:0] E_IDLE = 8'b0000_0000;
    localparam logic [7:0] E_CAP  = 8'b1000_1000;
    localparam logic [7:0] E_DONE = 8'b0100_0000;

    function automatic logic [7:0] e_sh(input logic sv, input logic sd, input logic mr);
        return {1'b1, 1'b0, 1'b1, 1'b1, sv & mr, mr, sv, sd};
    endfunction

    typedef struct packed {
        logic       st;
        logic       cp;
        logic       sv;
        logic       sd;
        logic       mr;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic apply(input logic st, input logic cp, input logic sv,
                         input logic sd, input logic mr,
                         input logic [7:0] exp, input string tag);
        logic [7:0] act;
        logic       exp_md;
        @(negedge clk);
        start = st; capture_en = cp; s_valid = sv; s_data = sd; m_ready = mr;
        #1;
        act    = {busy, done, scan_mode, scan_en, scan_ce, s_ready, m_valid, scan_si};
        exp_md = exp[5] ? sb[0] : 1'b0;
        vectors++;
        if (act !== exp || m_data !== exp_md) begin
            miscompares++;
            $display("FAIL %s: got ctrl=%b m_data=%b, expected ctrl=%b m_data=%b",
                     tag, act, m_data, exp, exp_md);
        end
        // Advance the scoreboard by what the chain should do on this edge.
        if (exp[4] && exp[3]) begin
            void'(sb.pop_front());
            sb.push_back(sd);
        end else if (exp[3]) begin
            sb = '{1'b0, 1'b0, 1'b0, 1'b0};
        end
    endtask

    task automatic check_bit(input logic act, input logic exp, input string tag);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", tag, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        sb = '{1'b0, 1'b0, 1'b0, 1'b0};
        global_resetn = 1'b0;
        start = 0; capture_en = 0; s_valid = 0; s_data = 0; m_ready = 0;
`ifdef SCAN_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        check_bit(|{busy, done, s_ready, m_valid, m_data, scan_mode, scan_en, scan_ce, scan_si},
                  1'b0, "reset_outputs");
        @(negedge clk);
        global_resetn = 1'b1;

        // Op A: no capture, 1,0,1,1. Op B: capture, reads A back. Op C reads zeros.
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, e_sh(1, 1, 1)});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, e_sh(1, 0, 1)});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, e_sh(1, 1, 1)});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, e_sh(1, 1, 1)});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_DONE});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, e_sh(1, 0, 1)});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, e_sh(1, 1, 1)});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, e_sh(1, 0, 1)});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, e_sh(1, 0, 1)});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_CAP});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_DONE});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, e_sh(1, 1, 1)});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, e_sh(1, 1, 1)});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, e_sh(1, 1, 1)});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, e_sh(1, 0, 1)});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_DONE});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE});
        foreach (tbl[i])
            apply(tbl[i].st, tbl[i].cp, tbl[i].sv, tbl[i].sd, tbl[i].mr, tbl[i].exp,
                  $sformatf("table[%0d]", i));

        // Stall: m_ready low for 3 cycles mid-shift delays done by exactly 3.
        apply(1, 0, 0, 0, 0, E_IDLE, "stall_start");
        apply(0, 0, 1, 0, 1, e_sh(1, 0, 1), "stall_b0");
        apply(0, 0, 1, 1, 1, e_sh(1, 1, 1), "stall_b1");
        for (int i = 0; i < 3; i++)
            apply(0, 0, 1, 0, 0, e_sh(1, 0, 0), $sformatf("stall_hold%0d", i));
        apply(0, 0, 1, 1, 1, e_sh(1, 1, 1), "stall_b2");
        apply(0, 0, 1, 0, 1, e_sh(1, 0, 1), "stall_b3");
        apply(0, 0, 0, 0, 0, E_DONE, "stall_done");

        // start held high: pulses while busy ignored, DONE chains straight to SHIFT.
        apply(1, 0, 0, 0, 0, E_IDLE, "b2b_start");
        apply(1, 1, 1, 1, 1, e_sh(1, 1, 1), "b2b_b0");
        apply(1, 1, 1, 1, 1, e_sh(1, 1, 1), "b2b_b1");
        apply(1, 1, 1, 0, 1, e_sh(1, 0, 1), "b2b_b2");
        apply(1, 1, 1, 1, 1, e_sh(1, 1, 1), "b2b_b3");
        apply(1, 1, 0, 0, 0, E_DONE, "b2b_done");
        apply(0, 0, 1, 0, 1, e_sh(1, 0, 1), "b2b2_b0");
        apply(0, 0, 1, 0, 1, e_sh(1, 0, 1), "b2b2_b1");
        apply(0, 0, 1, 1, 1, e_sh(1, 1, 1), "b2b2_b2");
        apply(0, 0, 1, 0, 1, e_sh(1, 0, 1), "b2b2_b3");
        apply(0, 0, 0, 0, 0, E_CAP, "b2b2_cap");
        apply(0, 0, 0, 0, 0, E_DONE, "b2b2_done");
        apply(0, 0, 0, 0, 0, E_IDLE, "b2b2_idle");

        // Reset mid-shift: outputs drop in the same cycle; next op starts from cnt 0.
        apply(1, 0, 0, 0, 0, E_IDLE, "rst_start");
        apply(0, 0, 1, 1, 1, e_sh(1, 1, 1), "rst_b0");
        apply(0, 0, 1, 0, 1, e_sh(1, 0, 1), "rst_b1");
        @(negedge clk);
        global_resetn = 1'b0;
        #1;
        check_bit(|{busy, scan_en, scan_mode, scan_ce, done}, 1'b0, "rst_mid_shift");
        @(negedge clk);
        global_resetn = 1'b1;
        apply(0, 0, 1, 1, 1, E_IDLE, "rst_idle_after");
        apply(1, 0, 0, 0, 0, E_IDLE, "rst2_start");
        apply(0, 0, 1, 1, 1, e_sh(1, 1, 1), "rst2_b0");
        apply(0, 0, 1, 1, 1, e_sh(1, 1, 1), "rst2_b1");
        apply(0, 0, 1, 0, 1, e_sh(1, 0, 1), "rst2_b2");
        apply(0, 0, 1, 1, 1, e_sh(1, 1, 1), "rst2_b3");
        apply(0, 0, 0, 0, 0, E_DONE, "rst2_done");

`ifdef SCAN_CTRL_ABORT_EN
        // Abort at beat 2 of 4: no beat on that edge, IDLE next, sticky flag.
        apply(1, 0, 0, 0, 0, E_IDLE, "abt_start");
        apply(0, 0, 1, 1, 1, e_sh(1, 1, 1), "abt_b0");
        apply(0, 0, 1, 0, 1, e_sh(1, 0, 1), "abt_b1");
        abort = 1'b1;
        apply(0, 0, 1, 1, 1, 8'b1011_0001, "abt_cycle");
        abort = 1'b0;
        apply(0, 0, 0, 0, 0, E_IDLE, "abt_idle");
        check_bit(aborted, 1'b1, "aborted_set");
        apply(1, 0, 0, 0, 0, E_IDLE, "abt_restart");
        check_bit(aborted, 1'b1, "aborted_held");
        apply(0, 0, 1, 1, 1, e_sh(1, 1, 1), "abt2_b0");
        check_bit(aborted, 1'b0, "aborted_cleared");
        apply(0, 0, 1, 1, 1, e_sh(1, 1, 1), "abt2_b1");
        apply(0, 0, 1, 1, 1, e_sh(1, 1, 1), "abt2_b2");
        apply(0, 0, 1, 1, 1, e_sh(1, 1, 1), "abt2_b3");
        apply(0, 0, 0, 0, 0, E_DONE, "abt2_done");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
